// File: rtl/pc_jump_unit_pkg.sv
// Shared definitions for the program-counter / jump unit and the CPU decoder
// that reuses its branch-condition logic.
package pc_jump_unit_pkg;

   localparam int PC_W = 16;

   // Bit positions inside the instruction jump field {j1,j2,j3}
   localparam int JLT = 2;
   localparam int JEQ = 1;
   localparam int JGT = 0;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/pc_jump_unit_cond.sv
// Branch condition evaluation from the ALU flags and the jump field.
// The zr=1/ng=1 combination is evaluated literally, with no special handling.
module jump_cond
   import pc_jump_unit_pkg::*;
(
   input  logic       zr,
   input  logic       ng,
   input  logic       is_c,
   input  logic [2:0] jmp,
   output logic       taken
);

   logic w_lt;
   logic w_eq;
   logic w_gt;

   assign w_lt  = jmp[JLT] & ng;
   assign w_eq  = jmp[JEQ] & zr;
   assign w_gt  = jmp[JGT] & ~zr & ~ng;
   assign taken = is_c & (w_lt | w_eq | w_gt);

endmodule

// File: rtl/pc_jump_unit.sv
// Program counter with conditional jump, a one-cycle boot slot after reset,
// and a sticky halt when a taken jump targets its own address.
module pc_jump_unit
   import pc_jump_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            zr,
   input  logic            ng,
   input  logic            is_c,
   input  logic [2:0]      jmp,
   input  logic [PC_W-1:0] target,
   input  logic            stall,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            jump_taken,
   output logic            halted
);

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_jump_taken;

   state_t          w_state_nxt;
   logic [PC_W-1:0] w_pc_nxt;
   logic            w_jump_nxt;
   logic            w_taken;

   jump_cond u_jump_cond (
      .zr    (zr),
      .ng    (ng),
      .is_c  (is_c),
      .jmp   (jmp),
      .taken (w_taken)
   );

   // A taken jump whose target equals the current pc is a self-loop: freeze there.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_jump_nxt  = 1'b0;
      case (r_state)
         ST_BOOT: begin
            if (!stall) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!stall) begin
               w_jump_nxt = w_taken;
               if (w_taken) begin
                  w_pc_nxt = target;
                  if (target == r_pc) w_state_nxt = ST_HALT;
               end else begin
                  w_pc_nxt = r_pc + PC_W'(1);
               end
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_BOOT;
            w_pc_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BOOT;
         r_pc         <= '0;
         r_jump_taken <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_jump_taken <= w_jump_nxt;
      end
   end

   assign pc          = r_pc;
   assign jump_taken  = r_jump_taken;
   assign fetch_valid = (r_state == ST_RUN);
   assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit with a reference model feeding a scoreboard.
module tb_pc_jump_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        zr;
   logic        ng;
   logic        is_c;
   logic [2:0]  jmp;
   logic [15:0] target;
   logic        stall;
   logic [15:0] pc;
   logic        fetch_valid;
   logic        jump_taken;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] pc;
      logic        fv;
      logic        jt;
      logic        h;
   } exp_t;

   exp_t sb[$];

   // Reference model state: 0 = boot, 1 = run, 2 = halt
   int          m_state;
   logic [15:0] m_pc;
   logic        m_jt;

   always #5 clk = ~clk;

   pc_jump_unit dut (
      .clk         (clk),
      .reset       (reset),
      .zr          (zr),
      .ng          (ng),
      .is_c        (is_c),
      .jmp         (jmp),
      .target      (target),
      .stall       (stall),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .jump_taken  (jump_taken),
      .halted      (halted)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic ref_taken(input logic z, input logic n, input logic c,
                                      input logic [2:0] j);
      logic lt_hit, eq_hit, gt_hit;
      lt_hit = j[2] && n;
      eq_hit = j[1] && z;
      gt_hit = j[0] && !z && !n;
      return c && (lt_hit || eq_hit || gt_hit);
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".pc"}, pc, e.pc);
         chk({tag, ".fetch_valid"}, 16'(fetch_valid), 16'(e.fv));
         chk({tag, ".jump_taken"}, 16'(jump_taken), 16'(e.jt));
         chk({tag, ".halted"}, 16'(halted), 16'(e.h));
      end
   endtask

   task automatic cycle(input string tag, input logic z, input logic n, input logic c,
                        input logic [2:0] j, input logic [15:0] t, input logic s);
      exp_t e;
      logic tk;
      zr = z; ng = n; is_c = c; jmp = j; target = t; stall = s;
      tk   = ref_taken(z, n, c, j);
      m_jt = 1'b0;
      case (m_state)
         0: if (!s) m_state = 1;
         1: if (!s) begin
               if (tk) begin
                  m_jt = 1'b1;
                  if (t == m_pc) m_state = 2;
                  else m_pc = t;
               end else begin
                  m_pc = m_pc + 16'd1;
               end
            end
         default: ;
      endcase
      e.pc = m_pc;
      e.fv = (m_state == 1);
      e.jt = m_jt;
      e.h  = (m_state == 2);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, 1'b0, 3'b000, 16'h1234, 1'b0);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = 16'h0000;
      m_jt    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".pc"}, pc, 16'h0000);
      chk({tag, ".fetch_valid"}, 16'(fetch_valid), 16'h0);
      chk({tag, ".jump_taken"}, 16'(jump_taken), 16'h0);
      chk({tag, ".halted"}, 16'(halted), 16'h0);
   endtask

   // Assert reset away from any clock edge, check the immediate effect, release on negedge.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_outputs(tag);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs({tag, "_boot"});
   endtask

   initial begin
      reset = 1'b0; zr = 1'b0; ng = 1'b0; is_c = 1'b0; jmp = 3'b000;
      target = 16'h0000; stall = 1'b0;
      model_reset();
      #2;
      do_reset("por");

      idle("seq", 4);

      idle("to5", 2);
      cycle("jeq_taken", 1'b1, 1'b0, 1'b1, 3'b010, 16'h0100, 1'b0);
      idle("after_jeq", 1);
      cycle("back_to5", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0005, 1'b0);
      cycle("jeq_not", 1'b0, 1'b0, 1'b1, 3'b010, 16'h0100, 1'b0);

      for (int j = 0; j < 8; j++) begin
         for (int f = 0; f < 3; f++) begin
            cycle("sweep", (f == 1), (f == 2), 1'b1, 3'(j), 16'(16'h4000 + ((j * 3 + f) << 8)), 1'b0);
         end
      end
      cycle("flags11_lt", 1'b1, 1'b1, 1'b1, 3'b100, 16'h7000, 1'b0);
      cycle("flags11_gt", 1'b1, 1'b1, 1'b1, 3'b001, 16'h7100, 1'b0);
      cycle("not_c", 1'b0, 1'b0, 1'b0, 3'b111, 16'h7200, 1'b0);

      cycle("to_ffff", 1'b0, 1'b0, 1'b1, 3'b111, 16'hFFFF, 1'b0);
      idle("wrap", 2);

      for (int k = 0; k < 3; k++) cycle("stall_hold", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0300, 1'b1);
      cycle("stall_release", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0300, 1'b0);
      idle("post_stall", 1);

      cycle("to_10", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0010, 1'b0);
      cycle("self_jump", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0010, 1'b0);
      for (int k = 0; k < 5; k++)
         cycle("halt_hold", 1'(k), 1'b0, 1'b1, 3'(k + 3), 16'(16'h0020 + k), (k == 2));

      do_reset("halt_reset");
      cycle("boot_stall", 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b1);
      idle("boot_exit", 3);

      for (int k = 0; k < 2; k++) cycle("mid_stall", 1'b0, 1'b0, 1'b1, 3'b111, 16'h0500, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("stall_reset");
      #2;
      reset = 1'b0;
      idle("after_stall_reset", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_jump_unit.md
PC_JUMP_UNIT -- requirements
Module: pc_jump_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge system clock.
REQ-002 The block SHALL provide reset as input 1, asynchronous active-high reset, named reset.
REQ-003 The block SHALL provide zr as input 1, the ALU zero flag produced by the OR-tree zero detector (1 = ALU out is zero).
REQ-004 The block SHALL provide ng as input 1, the ALU negative flag (ALU out bit 15).
REQ-005 The block SHALL provide is_c as input 1, asserted when the current instruction is a C-instruction.
REQ-006 The block SHALL provide jmp as input 3, the instruction jump field {j1,j2,j3} = {lt,eq,gt}.
REQ-007 The block SHALL provide target as input 16, the A-register value used as the jump destination.
REQ-008 The block SHALL provide stall as input 1, which holds PC and state for the cycle.
REQ-009 The block SHALL provide pc as output 16, the current fetch address.
REQ-010 The block SHALL provide fetch_valid as output 1, asserted when pc addresses an instruction to execute.
REQ-011 The block SHALL provide jump_taken as output 1, a registered pulse set for one cycle after a taken jump updates pc.
REQ-012 The block SHALL provide halted as output 1, asserted once a jump-to-self is detected.

Function
REQ-013 The block SHALL compute taken = is_c & ((jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&~zr&~ng)) combinationally each cycle.
REQ-014 The block SHALL implement states BOOT, RUN and HALT.
REQ-015 BOOT SHALL be entered on reset; it SHALL hold pc=0 and fetch_valid=0 for exactly one cycle, then go to RUN unless stall is high, in which case it remains in BOOT.
REQ-016 In RUN with stall=0, pc SHALL load target when taken=1 and otherwise increment by 1, with one-cycle latency.
REQ-017 pc increment SHALL wrap modulo 2^16: 0xFFFF -> 0x0000, with no flag raised.
REQ-018 In RUN with stall=1, pc, state and halted SHALL hold, and jump_taken SHALL be 0 on the next cycle.
REQ-019 In RUN, taken=1 with target == pc and stall=0 SHALL transition to HALT; pc SHALL remain at target and halted SHALL rise on the next edge.
REQ-020 HALT SHALL be exited only by reset; pc SHALL be frozen, fetch_valid=0 and halted=1, and inputs SHALL be ignored.
REQ-021 fetch_valid SHALL be 1 only in RUN.
REQ-022 jump_taken SHALL equal the registered value of (state==RUN & ~stall & taken), including the self-jump that enters HALT.
REQ-023 zr=1 and ng=1 together is an illegal flag combination; the block SHALL evaluate REQ-013 literally with no error handling.

Reset
REQ-024 Reset assertion SHALL force pc=0x0000, state=BOOT, fetch_valid=0, jump_taken=0 and halted=0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-operation, including while in HALT or during stall, SHALL abandon any pending jump.
REQ-026 After reset deassertion, the first clk edge SHALL act as the BOOT cycle.

Structure
REQ-027 A shared package SHALL hold PC_W=16, the jump field bit positions (JLT=2, JEQ=1, JGT=0) and the state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2).
REQ-028 The condition logic of REQ-013 SHALL be a combinational sub-module jump_cond (inputs zr, ng, is_c, jmp; output taken), reused by the CPU decoder.
REQ-029 All state SHALL be in pc_jump_unit, in one clocked process with async reset.

Verification
REQ-030 Reset release followed by 4 cycles with is_c=0 and stall=0 SHALL give pc sequence 0, 0, 1, 2, 3, with fetch_valid low on the first cycle only.
REQ-031 At pc=0x0005 with is_c=1, jmp=3'b010, zr=1, ng=0 and target=0x0100 SHALL give pc=0x0100 next cycle and a one-cycle jump_taken pulse; repeating with zr=0 SHALL give pc=0x0006 and jump_taken=0.
REQ-032 The bench SHALL sweep all 8 jmp values against flag combinations (zr,ng) in {(0,0), (1,0), (0,1)}, and pc SHALL match a reference model of REQ-013.
REQ-033 Jumping to target=0xFFFF and then running with no jump SHALL give pc 0xFFFF -> 0x0000 -> 0x0001.
REQ-034 At pc=0x0010 with jmp=3'b111 and target=0x0010 SHALL raise halted next cycle; 5 further cycles of varied inputs SHALL leave pc at 0x0010 and halted at 1.
REQ-035 stall=1 for 3 cycles while taken=1 SHALL leave pc unchanged and jump_taken=0; stall=0 SHALL then apply the jump; reset pulsed asynchronously mid-stall SHALL set pc=0 before the next edge.
